// File: rtl/instr_prog_loader_if.sv
// Field-bundle handshake between an instruction source and the program loader.
// The source drives a decoded instruction plus in_last; the loader answers with in_ready.
interface instr_prog_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [11:0] in_imm;
  logic        in_last;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
    output in_ready
  );
endinterface

// File: rtl/instr_prog_loader.sv
// Encodes decoded instruction bundles into RV32I words and writes them
// sequentially into instruction memory, one word per two cycles at most.
module instr_prog_loader #(
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  instr_prog_loader_if.slave    bus,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [AW:0]           instr_count,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  localparam logic [2:0] OP_LW   = 3'd0;
  localparam logic [2:0] OP_SW   = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_SRL  = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  // For beq the immediate already holds offset bits [12:1], so imm[k] is offset bit k+1.
  function automatic logic [31:0] encode(
    input logic [2:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [11:0] imm
  );
    logic [31:0] w;
    w = 32'h0;
    case (op)
      OP_LW:   w = {imm, rs1, 3'b010, rd, 7'b0000011};
      OP_SW:   w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      OP_SUB:  w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      OP_XOR:  w = {7'b0000000, rs2, rs1, 3'b100, rd, 7'b0110011};
      OP_ADDI: w = {imm, rs1, 3'b000, rd, 7'b0010011};
      OP_SRL:  w = {7'b0000000, rs2, rs1, 3'b101, rd, 7'b0110011};
      OP_BEQ:  w = {imm[11], imm[9:4], rs2, rs1, 3'b000, imm[3:0], imm[10], 7'b1100011};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  state_t        state;
  logic [AW-1:0] ptr;
  logic          last_p0;
  logic [AW:0]   count_nxt;

  assign count_nxt = instr_count + (AW+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.in_ready <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      instr_count  <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      ptr          <= '0;
      last_p0      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= ACCEPT;
            bus.in_ready <= 1'b1;
            instr_count  <= '0;
            err          <= 1'b0;
            done         <= 1'b0;
            ptr          <= '0;
          end
        end

        // Capture stage: the word is encoded here so the write cycle only has to present it.
        ACCEPT: begin
          if (bus.in_valid) begin
            bus.in_ready <= 1'b0;
            if (bus.in_op == OP_ILL) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              mem_we    <= 1'b1;
              mem_addr  <= ptr;
              mem_wdata <= encode(bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
              last_p0   <= bus.in_last;
              state     <= WRITE;
            end
          end
        end

        // Write stage: one strobe cycle, then either finish or reopen the handshake.
        WRITE: begin
          mem_we      <= 1'b0;
          ptr         <= ptr + AW'(1);
          instr_count <= count_nxt;
          if (last_p0 || (count_nxt == (AW+1)'(DEPTH))) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            bus.in_ready <= 1'b1;
            state        <= ACCEPT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_prog_loader.sv
// Self-checking bench for instr_prog_loader: vector table, multi-cycle corner
// sequences and randomized sessions against a field-level encoding model.
module tb_instr_prog_loader;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_wdata;
  logic [AW:0]       instr_count;
  logic              done;
  logic              err;

  instr_prog_loader_if bus ();

  instr_prog_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .instr_count (instr_count),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  int unsigned cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int unsigned   t;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    wr_t w;
    if (mem_we) begin
      w.addr = mem_addr;
      w.data = mem_wdata;
      w.t    = cyc;
      wr_q.push_back(w);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // Reference encoder built from the RV32I field layouts; beq works on the byte offset.
  function automatic logic [31:0] ref_enc(input int unsigned op, input int unsigned rd,
                                          input int unsigned rs1, input int unsigned rs2,
                                          input int unsigned imm);
    int unsigned w;
    int unsigned off;
    w = 0;
    case (op)
      0: w = (imm << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
      1: w = ((imm >> 5) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) | ((imm & 31) << 7) | 'h23;
      2: w = (32'h20 << 25) | (rs2 << 20) | (rs1 << 15) | (rd << 7) | 'h33;
      3: w = (rs2 << 20) | (rs1 << 15) | (4 << 12) | (rd << 7) | 'h33;
      4: w = (imm << 20) | (rs1 << 15) | (rd << 7) | 'h13;
      5: w = (rs2 << 20) | (rs1 << 15) | (5 << 12) | (rd << 7) | 'h33;
      6: begin
        off = imm * 2;
        w = (((off >> 12) & 1) << 31) | (((off >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
          | (((off >> 1) & 15) << 8) | (((off >> 11) & 1) << 7) | 'h63;
      end
      default: w = 0;
    endcase
    return w;
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int unsigned op, input int unsigned rd, input int unsigned rs1,
                      input int unsigned rs2, input int unsigned imm, input logic last,
                      input bit hold);
    bit got;
    got          = 1'b0;
    bus.in_op    = op[2:0];
    bus.in_rd    = rd[4:0];
    bus.in_rs1   = rs1[4:0];
    bus.in_rs2   = rs2[4:0];
    bus.in_imm   = imm[11:0];
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) chk("accept_timeout", 32'(got), 32'd1);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic cmp_writes(input string tag);
    int n;
    chk($sformatf("%s_nwrites", tag), 32'(wr_q.size()), 32'(exp_q.size()));
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wr_q[i].addr), 32'(i));
      chk($sformatf("%s_data%0d", tag, i), wr_q[i].data, exp_q[i]);
    end
  endtask

  typedef struct {
    int unsigned op, rd, rs1, rs2, imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned len, op;
    logic        exp_err;

    vt[0] = '{op: 4, rd: 1,  rs1: 0,  rs2: 0,  imm: 5,     exp: 32'h00500093};
    vt[1] = '{op: 2, rd: 3,  rs1: 1,  rs2: 2,  imm: 12'hABC, exp: 32'h402081B3};
    vt[2] = '{op: 0, rd: 5,  rs1: 0,  rs2: 17, imm: 8,     exp: 32'h00802283};
    vt[3] = '{op: 1, rd: 31, rs1: 0,  rs2: 5,  imm: 4,     exp: 32'h00502223};
    vt[4] = '{op: 6, rd: 9,  rs1: 1,  rs2: 2,  imm: 12'hFFC, exp: 32'hFE208CE3};
    vt[5] = '{op: 3, rd: 7,  rs1: 3,  rs2: 4,  imm: 0,     exp: 32'h0041C3B3};
    vt[6] = '{op: 5, rd: 10, rs1: 11, rs2: 12, imm: 77,    exp: 32'h00C5D533};

    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_rd    = '0;
    bus.in_rs1   = '0;
    bus.in_rs2   = '0;
    bus.in_imm   = '0;
    bus.in_last  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // Single-instruction sessions from the vector table.
    for (int v = 0; v < 7; v++) begin
      do_start();
      wr_q.delete();
      exp_q.delete();
      exp_q.push_back(vt[v].exp);
      send(vt[v].op, vt[v].rd, vt[v].rs1, vt[v].rs2, vt[v].imm, 1'b1, 1'b0);
      wait_done($sformatf("vec%0d_done", v));
      cmp_writes($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_count", v), 32'(instr_count), 32'd1);
      chk($sformatf("vec%0d_err", v), 32'(err), 32'd0);
      chk($sformatf("vec%0d_hold", v), mem_wdata, vt[v].exp);
    end

    // Back-to-back bundles with in_valid held high.
    do_start();
    wr_q.delete();
    exp_q = '{32'h402081B3, 32'h00802283, 32'h00502223};
    send(2, 3, 1, 2, 0, 1'b0, 1'b1);
    send(0, 5, 0, 0, 8, 1'b0, 1'b1);
    send(1, 0, 0, 5, 4, 1'b1, 1'b0);
    wait_done("b2b_done");
    cmp_writes("b2b");
    chk("b2b_count", 32'(instr_count), 32'd3);
    if (wr_q.size() == 3) begin
      chk("b2b_gap1", wr_q[1].t - wr_q[0].t, 32'd2);
      chk("b2b_gap2", wr_q[2].t - wr_q[1].t, 32'd2);
    end

    // Fill all DEPTH words without in_last.
    do_start();
    wr_q.delete();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(ref_enc(3, i % 32, (i * 3) % 32, (i * 7) % 32, i));
      send(3, i % 32, (i * 3) % 32, (i * 7) % 32, i, 1'b0, 1'b1);
    end
    wait_done("full_done");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("full_ready%0d", i), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    cmp_writes("full");
    chk("full_count", 32'(instr_count), 32'(DEPTH));

    // Legal op followed by an illegal op.
    do_start();
    wr_q.delete();
    exp_q = '{32'h00500093};
    send(4, 1, 0, 0, 5, 1'b0, 1'b1);
    send(7, 1, 2, 3, 4, 1'b0, 1'b0);
    wait_done("ill_done");
    cmp_writes("ill");
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_count", 32'(instr_count), 32'd1);
    do_start();
    chk("ill_restart_err", 32'(err), 32'd0);
    chk("ill_restart_count", 32'(instr_count), 32'd0);
    chk("ill_restart_done", 32'(done), 32'd0);
    wr_q.delete();
    exp_q.delete();
    send(7, 0, 0, 0, 0, 1'b1, 1'b0);
    wait_done("ill_last_done");
    cmp_writes("ill_last");
    chk("ill_last_err", 32'(err), 32'd1);

    // Reset dropped during the second word's write cycle.
    do_start();
    wr_q.delete();
    send(4, 1, 0, 0, 5, 1'b0, 1'b0);
    bus.in_op    = 3'd0;
    bus.in_rd    = 5'd5;
    bus.in_imm   = 12'd8;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rw_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("rw_we_before", 32'(mem_we), 32'd1);
    chk("rw_addr_before", 32'(mem_addr), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_we", 32'(mem_we), 32'd0);
    chk("rw_addr", 32'(mem_addr), 32'd0);
    chk("rw_wdata", mem_wdata, 32'd0);
    chk("rw_count", 32'(instr_count), 32'd0);
    chk("rw_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rw_nwrites", 32'(wr_q.size()), 32'd1);
    do_start();
    wr_q.delete();
    exp_q = '{32'h00802283};
    send(0, 5, 0, 0, 8, 1'b1, 1'b0);
    wait_done("rw_restart_done");
    cmp_writes("rw_restart");

    // Randomized sessions against the reference model.
    for (int s = 0; s < 25; s++) begin
      do_start();
      wr_q.delete();
      exp_q.delete();
      exp_err = 1'b0;
      len = $urandom_range(1, 8);
      for (int i = 0; i < int'(len); i++) begin
        int unsigned rd, rs1, rs2, imm;
        op  = ($urandom_range(0, 11) == 0) ? 7 : $urandom_range(0, 6);
        rd  = $urandom_range(0, 31);
        rs1 = $urandom_range(0, 31);
        rs2 = $urandom_range(0, 31);
        imm = $urandom_range(0, 4095);
        send(op, rd, rs1, rs2, imm, (i == int'(len) - 1), ($urandom_range(0, 1) == 1));
        if (op == 7) begin
          exp_err = 1'b1;
          break;
        end
        exp_q.push_back(ref_enc(op, rd, rs1, rs2, imm));
      end
      bus.in_valid = 1'b0;
      wait_done($sformatf("rnd%0d_done", s));
      cmp_writes($sformatf("rnd%0d", s));
      chk($sformatf("rnd%0d_count", s), 32'(instr_count), 32'(exp_q.size()));
      chk($sformatf("rnd%0d_err", s), 32'(err), 32'(exp_err));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
